uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that feeds the `serial_rx` path of `core_top`. It turns the asynchronous board pin into framed, parallel bytes with a one-cycle valid strobe. It samples at mid-bit using a counter derived from `CLK_HZ`/`BIT_RATE`, and reports framing errors and line breaks. It uses the same parameter set as the `core_top` UART instance, so the board tops can pass their settings through unchanged.

## Interface
Parameters:
- `CLK_HZ`, 25000000, system clock frequency in Hz
- `BIT_RATE`, 9600, serial bit rate in baud
- `PAYLOAD_BITS`, 8, data bits per frame (1..16), LSB first, no parity, one stop bit

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `uart_rxd`  in  1  asynchronous serial line, idle high
- `uart_rx_en`  in  1  receive enable; sampled only in IDLE
- `uart_rx_data`  out  PAYLOAD_BITS  last good frame; holds until the next valid
- `uart_rx_valid`  out  1  one-cycle strobe: `uart_rx_data` updated this cycle
- `uart_rx_ferr`  out  1  one-cycle strobe: stop bit sampled low
- `uart_rx_break`  out  1  one-cycle strobe: framing error with all data bits 0

## Operation
- Constants:
  - `CPB = CLK_HZ/BIT_RATE` (integer division, 2604 at defaults).
  - `HALF = CPB/2`.
  - Counter width is `$clog2(CPB)`.
  - Bit index width is `$clog2(PAYLOAD_BITS+1)`.
- Input synchronizer:
  - 2-FF chain on `uart_rxd`; both flops reset to 1.
  - `rxs` is the second flop. All decisions use `rxs` only.
- FSM states: IDLE, START, DATA, STOP, RECOVER.
- IDLE:
  - Counter and index are held at 0.
  - If `rxs==0 && uart_rx_en`, go to START.
- START:
  - Counter increments each cycle.
  - At count `HALF-1`, sample `rxs`:
    - If 0, go to DATA and clear the counter.
    - If 1, the start was a glitch: return to IDLE with no strobe.
- DATA:
  - At count `CPB-1`, sample `rxs` into the shift register (shift right, new bit at MSB), clear the counter and increment the index.
  - After the `PAYLOAD_BITS`-th sample, go to STOP.
- STOP:
  - At count `CPB-1`, sample `rxs`.
  - If 1: load `uart_rx_data` from the shift register, pulse `uart_rx_valid`, go to IDLE.
  - If 0: pulse `uart_rx_ferr`, and also `uart_rx_break` if the shift register is all 0. `uart_rx_data` is not updated. Go to RECOVER.
- RECOVER:
  - Wait until `rxs==1`, then go to IDLE.
  - This prevents a held-low break from re-triggering frames.
- `uart_rx_en` deasserted mid-frame: the current frame completes normally; no new start is accepted.
- Strobes are mutually exclusive with valid. `ferr` and `break` may assert together.

## Timing
- Reset values:
  - FSM in IDLE; sync flops = 1; counter, index and shift register = 0.
  - `uart_rx_data = 0`; `uart_rx_valid`, `uart_rx_ferr` and `uart_rx_break` = 0.
- Reset mid-frame: on the next edge with `rst_n==0`, all state returns to reset values, no strobe is emitted, and the partial frame is discarded.
- Latency: let edge 0 be the first `clk` edge at which `uart_rxd` is sampled low. `uart_rx_valid` is high during the cycle after edge `2 + HALF + (PAYLOAD_BITS+1)*CPB`.
- Back-to-back frames: a start bit immediately following a good stop bit is accepted. The FSM re-enters IDLE about `HALF` cycles before the stop-bit end, so no gap is required.
- Sampling point sits at `HALF` ± 1 cycle within each bit. The tolerated baud mismatch is about ±4% at `PAYLOAD_BITS=8`.
- All outputs are registered; there are no combinational paths from `uart_rxd`.

## Structure
- Shared `uart_pkg`:
  - FSM state encoding (5 states, 3-bit localparams).
  - `CPB`/`HALF` derivation as a function of `CLK_HZ` and `BIT_RATE`, so a future `uart_tx` uses identical timing.
- One sub-module: `sync_2ff` (parameterized reset value, here 1). It is reused for the `switch_n*` inputs.

## Test plan
All scenarios use `CLK_HZ=1000000`, `BIT_RATE=100000` (`CPB=10`, `HALF=5`), `PAYLOAD_BITS=8`.

1. Reset, then send frame 0xA5 with a good stop bit → a single `uart_rx_valid` pulse with `uart_rx_data=0xA5`, 2+5+90=97 edges after the start-bit edge. `ferr` and `break` stay 0.
2. Send 0x00 and 0xFF back-to-back with no idle gap → two valid pulses 100 cycles apart, data 0x00 then 0xFF.
3. Send a 3-cycle low glitch on idle line → no strobes; FSM returns to IDLE; `uart_rx_data` is unchanged.
4. Send frame 0x3C with the stop bit low → `uart_rx_ferr` pulses, `break`=0, `uart_rx_data` keeps its previous value. Next good frame 0x11 → valid with 0x11.
5. Hold the line low for 300 cycles, then release → exactly one `ferr`+`break` pulse, no further strobes while low. A good frame after release → valid.
6. Assert `rst_n=0` for one cycle in the middle of DATA of frame 0x5A → no strobes. Send frame 0xC3 after the line idles → valid with 0xC3.
7. Hold `uart_rx_en=0` and send 0x77 → no strobes. Deassert `uart_rx_en` mid-frame of 0x88 → valid with 0x88.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM state encoding and bit-timing
//               derivation, so receiver and transmitter agree on timing.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_STATE_W = 3;

  typedef enum logic [UART_STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } uart_state_e;

  // Clock cycles per serial bit (integer division).
  function automatic int uart_cpb(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Offset from the start-bit edge to its mid-point.
  function automatic int uart_half(input int clk_hz, input int bit_rate);
    return uart_cpb(clk_hz, bit_rate) / 2;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for asynchronous level inputs, with a
//               configurable reset value (idle level of the input).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture; the first stage may go metastable, the second settles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, 8N1-style framing with configurable payload
//               width. Mid-bit sampling, framing-error and break reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_ferr,
  output logic                    uart_rx_break
);

  localparam int CPB   = uart_cpb(CLK_HZ, BIT_RATE);
  localparam int HALF  = uart_half(CLK_HZ, BIT_RATE);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IDX_W = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(PAYLOAD_BITS - 1);

  logic rxs;

  uart_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic [IDX_W-1:0]        idx_q,   idx_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] data_q,  data_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q,  ferr_d;
  logic                    break_q, break_d;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync_rxd (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (uart_rxd),
    .q_o   (rxs)
  );

  // State register and all datapath/output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      break_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      break_q <= break_d;
    end
  end

  // Next-state logic: bit timing, data shifting and strobe generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    break_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxs && uart_rx_en) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF_M1) begin
          cnt_d   = '0;
          // A line that is high again at mid-start was only a glitch.
          state_d = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          // LSB arrives first, so shift right and insert at the MSB.
          shift_d = shift_q >> 1;
          shift_d[PAYLOAD_BITS-1] = rxs;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            break_d = (shift_q == '0);
            state_d = ST_RECOVER;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RECOVER: begin
        // Hold off until the line returns high so a long break yields one report.
        cnt_d = '0;
        idx_d = '0;
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign uart_rx_data  = data_q;
  assign uart_rx_valid = valid_q;
  assign uart_rx_ferr  = ferr_q;
  assign uart_rx_break = break_q;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx with a strobe scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLK_HZ   = 1000000;
  localparam int BIT_RATE = 100000;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int HALF     = CPB / 2;
  localparam int LAT      = 2 + HALF + 9 * CPB;

  typedef struct {
    logic       v;
    logic       f;
    logic       b;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic       rx_break;

  exp_t       sb[$];
  logic [7:0] model_data = 8'h00;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  uart_rx #(
    .CLK_HZ       (CLK_HZ),
    .BIT_RATE     (BIT_RATE),
    .PAYLOAD_BITS (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rxd      (rxd),
    .uart_rx_en    (en),
    .uart_rx_data  (rx_data),
    .uart_rx_valid (rx_valid),
    .uart_rx_ferr  (rx_ferr),
    .uart_rx_break (rx_break)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle counter; a synchronous reset clears the held-data model.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) model_data = 8'h00;
  end

  // Compare strobes against the scoreboard and the held data every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (rx_valid || rx_ferr || rx_break) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", {29'd0, rx_valid, rx_ferr, rx_break}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("valid",   {31'd0, rx_valid}, {31'd0, e.v});
          chk("ferr",    {31'd0, rx_ferr},  {31'd0, e.f});
          chk("break",   {31'd0, rx_break}, {31'd0, e.b});
          chk("latency", cyc, e.cyc);
          if (e.v) model_data = e.d;
        end
      end
      chk("data_hold", {24'd0, rx_data}, {24'd0, model_data});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame starting now (callers sit 1 time unit after an edge).
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic expect_it, input int drop_en_bit);
    logic [9:0] fr;
    exp_t e;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == drop_en_bit) en = 1'b0;
      rxd = fr[i];
      if (i == 0 && expect_it) begin
        e.v   = stop;
        e.f   = ~stop;
        e.b   = ~stop && (b == 8'h00);
        e.d   = b;
        e.cyc = cyc + 1 + LAT;
        sb.push_back(e);
      end
      idle(CPB);
    end
    rxd = 1'b1;
  endtask

  task automatic check_empty(input string tag);
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    exp_t e;
    logic [9:0] fr;
    rst_n = 1'b0;
    rxd   = 1'b1;
    en    = 1'b1;
    idle(3);
    chk("rst_data",  {24'd0, rx_data}, 32'd0);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_ferr",  {31'd0, rx_ferr}, 32'd0);
    chk("rst_break", {31'd0, rx_break}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    // 1: single good frame
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    idle(20);
    check_empty("t1_pending");

    // 2: back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b1, -1);
    send_frame(8'hFF, 1'b1, 1'b1, -1);
    idle(20);
    check_empty("t2_pending");

    // 3: short low glitch on idle line
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(30);
    check_empty("t3_pending");
    chk("t3_data", {24'd0, rx_data}, 32'h000000FF);

    // 4: framing error, then a good frame
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    idle(20);
    send_frame(8'h11, 1'b1, 1'b1, -1);
    idle(20);
    check_empty("t4_pending");

    // 5: long break, then a good frame
    rxd   = 1'b0;
    e.v   = 1'b0;
    e.f   = 1'b1;
    e.b   = 1'b1;
    e.d   = 8'h00;
    e.cyc = cyc + 1 + LAT;
    sb.push_back(e);
    idle(300);
    rxd = 1'b1;
    idle(20);
    send_frame(8'h42, 1'b1, 1'b1, -1);
    idle(20);
    check_empty("t5_pending");

    // 6: reset in the middle of the data bits
    fr = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxd = fr[i];
      idle(CPB);
    end
    rst_n = 1'b0;
    rxd   = 1'b1;
    idle(1);
    rst_n = 1'b1;
    chk("t6_rst_data", {24'd0, rx_data}, 32'd0);
    idle(30);
    send_frame(8'hC3, 1'b1, 1'b1, -1);
    idle(20);
    check_empty("t6_pending");

    // 7: receiver disabled, then disabled mid-frame
    en = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0, -1);
    idle(20);
    en = 1'b1;
    idle(5);
    send_frame(8'h88, 1'b1, 1'b1, 3);
    idle(20);
    en = 1'b1;
    check_empty("t7_pending");
    chk("t7_data", {24'd0, rx_data}, 32'h00000088);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire
